// File: rtl/udp_echo_responder_pkg.sv
// rtl/udp_echo_responder_pkg.sv - shared states, port constant and bytes_valid encoding for the UDP echo responder
package udp_echo_responder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX_DATA,
    TX_WAIT,
    TX_HDR,
    TX_DATA,
    TX_COMMIT
  } state_t;

  localparam logic [15:0] UDP_ECHO_PORT = 16'd7;

  // bytes_valid carries 1..4; a full word is 4
  localparam logic [2:0] BV_FULL = 3'd4;

  function automatic logic [2:0] last_bytes_valid(input logic [1:0] len_lsbs);
    return (len_lsbs == 2'b00) ? BV_FULL : {1'b0, len_lsbs};
  endfunction

endpackage

// File: rtl/udp_echo_buffer.sv
// rtl/udp_echo_buffer.sv - single-clock simple dual-port payload RAM with registered read
module udp_echo_buffer #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/udp_echo_responder.sv
// rtl/udp_echo_responder.sv - UDP socket endpoint that buffers datagrams on one port and echoes them back
module udp_echo_responder
  import udp_echo_responder_pkg::*;
#(
  parameter logic [15:0] LISTEN_PORT = UDP_ECHO_PORT,
  parameter int          MAX_PAYLOAD = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_start,
  input  logic [31:0] rx_src_ip,
  input  logic [15:0] rx_src_port,
  input  logic [15:0] rx_dst_port,
  input  logic [15:0] rx_payload_len,
  input  logic        rx_data_valid,
  input  logic [2:0]  rx_bytes_valid,
  input  logic [31:0] rx_data,
  input  logic        rx_commit,
  input  logic        rx_drop,
  input  logic        tx_ready,
  output logic        tx_start,
  output logic [31:0] tx_dst_ip,
  output logic [15:0] tx_src_port,
  output logic [15:0] tx_dst_port,
  output logic [15:0] tx_payload_len,
  output logic        tx_data_valid,
  output logic [2:0]  tx_bytes_valid,
  output logic [31:0] tx_data,
  output logic        tx_commit,
  output logic [31:0] echo_count,
  output logic [31:0] drop_count
);

  localparam int DEPTH = MAX_PAYLOAD / 4;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]  DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [16:0]  MAX_LEN = 17'(MAX_PAYLOAD);

  state_t state, state_next;

  logic [31:0] src_ip;
  logic [15:0] src_port;
  logic [15:0] len;
  logic [AW:0] wr_ptr;
  logic [16:0] byte_cnt;
  logic        overflow;
  logic [AW:0] tx_idx;

  logic        port_match, accept, busy, rx_word, wr_en, commit_ok;
  logic        latch, drop_inc, tx_last;
  logic [16:0] byte_cnt_upd, len_words;
  logic        ovf_upd;
  logic [31:0] rd_data;
  logic [AW-1:0] rd_addr;

  assign port_match = (rx_dst_port == LISTEN_PORT);
  assign accept     = port_match && (rx_payload_len != 16'd0) && ({1'b0, rx_payload_len} <= MAX_LEN);
  assign busy       = (state == TX_WAIT) || (state == TX_HDR) || (state == TX_DATA) || (state == TX_COMMIT);

  // A word arriving with a commit is counted before the commit is judged
  assign rx_word      = (state == RX_DATA) && !rx_start && rx_data_valid;
  assign wr_en        = rx_word && (wr_ptr < DEPTH_W);
  assign byte_cnt_upd = byte_cnt + (rx_word ? {14'd0, rx_bytes_valid} : 17'd0);
  assign ovf_upd      = overflow || (rx_word && (wr_ptr >= DEPTH_W));
  assign commit_ok    = !ovf_upd && (byte_cnt_upd == {1'b0, len});

  assign len_words = ({1'b0, len} + 17'd3) >> 2;
  assign tx_last   = (state == TX_DATA) && ({{(16 - AW){1'b0}}, tx_idx} == len_words - 17'd1);
  // Word 0 is fetched in TX_HDR; each TX_DATA cycle prefetches the next word
  assign rd_addr   = (state == TX_HDR) ? '0 : tx_idx[AW-1:0] + AW'(1);

  always_comb begin
    state_next = state;
    latch      = 1'b0;
    drop_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_start) begin
          if (accept) begin
            latch      = 1'b1;
            state_next = RX_DATA;
          end else if (port_match) begin
            drop_inc = 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (rx_start) begin
          drop_inc = 1'b1;
          if (accept) latch = 1'b1;
          else        state_next = IDLE;
        end else if (rx_drop) begin
          drop_inc   = 1'b1;
          state_next = IDLE;
        end else if (rx_commit) begin
          if (commit_ok) begin
            state_next = TX_WAIT;
          end else begin
            drop_inc   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      TX_WAIT:   if (tx_ready) state_next = TX_HDR;
      TX_HDR:    state_next = TX_DATA;
      TX_DATA:   if (tx_last) state_next = TX_COMMIT;
      TX_COMMIT: state_next = IDLE;
      default:   state_next = IDLE;
    endcase
    if (busy && rx_start && port_match) drop_inc = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      src_ip     <= '0;
      src_port   <= '0;
      len        <= '0;
      wr_ptr     <= '0;
      byte_cnt   <= '0;
      overflow   <= 1'b0;
      tx_idx     <= '0;
      echo_count <= '0;
      drop_count <= '0;
    end else begin
      state <= state_next;
      if (latch) begin
        src_ip   <= rx_src_ip;
        src_port <= rx_src_port;
        len      <= rx_payload_len;
        wr_ptr   <= '0;
        byte_cnt <= '0;
        overflow <= 1'b0;
      end else if (rx_word) begin
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        byte_cnt <= byte_cnt_upd;
        overflow <= ovf_upd;
      end
      if (state == TX_HDR)       tx_idx <= '0;
      else if (state == TX_DATA) tx_idx <= tx_idx + 1'b1;
      if (drop_inc)              drop_count <= drop_count + 32'd1;
      if (state == TX_COMMIT)    echo_count <= echo_count + 32'd1;
    end
  end

  udp_echo_buffer #(.DEPTH(DEPTH), .AW(AW)) u_buffer (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (rx_data),
    .rd_en   ((state == TX_HDR) || (state == TX_DATA)),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign tx_start       = (state == TX_HDR);
  assign tx_dst_ip      = busy ? src_ip : '0;
  assign tx_src_port    = busy ? LISTEN_PORT : '0;
  assign tx_dst_port    = busy ? src_port : '0;
  assign tx_payload_len = busy ? len : '0;
  assign tx_data_valid  = (state == TX_DATA);
  assign tx_bytes_valid = (state != TX_DATA) ? 3'd0 : (tx_last ? last_bytes_valid(len[1:0]) : BV_FULL);
  assign tx_data        = tx_data_valid ? rd_data : '0;
  assign tx_commit      = (state == TX_COMMIT);

endmodule

// File: tb/tb_udp_echo_responder.sv
// tb/tb_udp_echo_responder.sv - directed and randomized echo checks against a byte-level datagram model
module tb_udp_echo_responder;

  logic        clk = 1'b0, rst = 1'b1;
  logic        rx_start = 1'b0, rx_data_valid = 1'b0, rx_commit = 1'b0, rx_drop = 1'b0, tx_ready = 1'b0;
  logic [31:0] rx_src_ip = '0, rx_data = '0;
  logic [15:0] rx_src_port = '0, rx_dst_port = '0, rx_payload_len = '0;
  logic [2:0]  rx_bytes_valid = '0;
  logic        tx_start, tx_data_valid, tx_commit;
  logic [31:0] tx_dst_ip, tx_data, echo_count, drop_count;
  logic [15:0] tx_src_port, tx_dst_port, tx_payload_len;
  logic [2:0]  tx_bytes_valid;

  udp_echo_responder #(.LISTEN_PORT(16'd7), .MAX_PAYLOAD(1024)) dut (
    .clk(clk), .rst(rst), .rx_start(rx_start), .rx_src_ip(rx_src_ip), .rx_src_port(rx_src_port),
    .rx_dst_port(rx_dst_port), .rx_payload_len(rx_payload_len), .rx_data_valid(rx_data_valid),
    .rx_bytes_valid(rx_bytes_valid), .rx_data(rx_data), .rx_commit(rx_commit), .rx_drop(rx_drop),
    .tx_ready(tx_ready), .tx_start(tx_start), .tx_dst_ip(tx_dst_ip), .tx_src_port(tx_src_port),
    .tx_dst_port(tx_dst_port), .tx_payload_len(tx_payload_len), .tx_data_valid(tx_data_valid),
    .tx_bytes_valid(tx_bytes_valid), .tx_data(tx_data), .tx_commit(tx_commit),
    .echo_count(echo_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ip;
    logic [15:0] sp;
    logic [15:0] dp;
    logic [15:0] len;
  } hdr_t;

  int total = 0, bad = 0, cyc = 0;
  int commits = 0, start_cyc = 0, first_cyc = -1, last_cyc = 0, commit_cyc = 0, rxc_cyc = 0, idle_nz = 0;
  int exp_echo = 0, exp_drop = 0;
  hdr_t        hq[$];
  logic [31:0] dq[$];
  logic [2:0]  bq[$];
  logic [7:0]  pay[0:1027];
  logic [7:0]  exp_pay[0:1027];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (tx_start) begin
      hq.push_back('{tx_dst_ip, tx_src_port, tx_dst_port, tx_payload_len});
      start_cyc = cyc;
      first_cyc = -1;
    end
    if (tx_data_valid) begin
      dq.push_back(tx_data);
      bq.push_back(tx_bytes_valid);
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
    end else if (tx_data !== 32'd0) begin
      idle_nz++;
    end
    if (tx_commit) begin
      commits++;
      commit_cyc = cyc;
    end
    if (rx_commit) rxc_cyc = cyc;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
  endtask

  task automatic send_dgram(input logic [15:0] dp, input logic [31:0] ip, input logic [15:0] sp,
                            input logic [15:0] len, input int nbytes, input bit do_drop, input bit gaps);
    rx_start = 1'b1; rx_dst_port = dp; rx_src_ip = ip; rx_src_port = sp; rx_payload_len = len;
    tick();
    rx_start = 1'b0;
    for (int w = 0; w * 4 < nbytes; w++) begin
      logic [31:0] word;
      word = '0;
      for (int b = 0; b < 4; b++) if (4 * w + b < nbytes) word[31 - 8 * b -: 8] = pay[4 * w + b];
      if (gaps && $urandom_range(0, 3) == 0) tick();
      rx_data_valid = 1'b1;
      rx_data = word;
      rx_bytes_valid = (nbytes - 4 * w >= 4) ? 3'd4 : 3'(nbytes - 4 * w);
      tick();
      rx_data_valid = 1'b0; rx_data = '0; rx_bytes_valid = '0;
    end
    if (do_drop) rx_drop = 1'b1;
    else         rx_commit = 1'b1;
    tick();
    rx_drop = 1'b0; rx_commit = 1'b0;
  endtask

  task automatic wait_commits(input int target, input int budget);
    int n;
    n = 0;
    while (commits < target && n < budget) begin
      tick();
      n++;
    end
    check("echo_timeout", 64'(commits >= target), 64'd1);
  endtask

  // Model: the echoed frame is the received byte stream, packed MSB-first, addressed back to the sender
  task automatic check_echo(input logic [31:0] ip, input logic [15:0] sp, input int len);
    hdr_t h;
    int nw;
    nw = (len + 3) / 4;
    check("hdr_count", 64'(hq.size()), 64'd1);
    if (hq.size() > 0) begin
      h = hq.pop_front();
      check("tx_dst_ip", 64'(h.ip), 64'(ip));
      check("tx_src_port", 64'(h.sp), 64'd7);
      check("tx_dst_port", 64'(h.dp), 64'(sp));
      check("tx_payload_len", 64'(h.len), 64'(len));
    end
    check("word_count", 64'(dq.size()), 64'(nw));
    for (int w = 0; w < nw && dq.size() > 0; w++) begin
      logic [31:0] ew;
      int rem;
      ew = '0;
      for (int b = 0; b < 4; b++) if (4 * w + b < len) ew[31 - 8 * b -: 8] = exp_pay[4 * w + b];
      rem = len - 4 * w;
      check($sformatf("tx_data[%0d]", w), 64'(dq.pop_front()), 64'(ew));
      check($sformatf("tx_bytes_valid[%0d]", w), 64'(bq.pop_front()), (rem >= 4) ? 64'd4 : 64'(rem));
    end
    check("data_first_after_start", 64'(first_cyc - start_cyc), 64'd1);
    check("data_contiguous", 64'(last_cyc - first_cyc + 1), 64'(nw));
    check("commit_after_last", 64'(commit_cyc - last_cyc), 64'd1);
    check("echo_count", 64'(echo_count), 64'(exp_echo));
    dq.delete();
    bq.delete();
  endtask

  task automatic check_quiet(input string tag, input int c0);
    repeat (12) tick();
    check({tag, "_no_tx_start"}, 64'(hq.size()), 64'd0);
    check({tag, "_no_commit"}, 64'(commits), 64'(c0));
    check({tag, "_drop_count"}, 64'(drop_count), 64'(exp_drop));
    check({tag, "_echo_count"}, 64'(echo_count), 64'(exp_echo));
  endtask

  initial begin
    int c0, n, len, nb, mode;
    logic [15:0] dp;

    repeat (3) tick();
    check("rst_tx_start", 64'(tx_start), 64'd0);
    check("rst_tx_data_valid", 64'(tx_data_valid), 64'd0);
    check("rst_tx_commit", 64'(tx_commit), 64'd0);
    check("rst_tx_dst_ip", 64'(tx_dst_ip), 64'd0);
    check("rst_tx_payload_len", 64'(tx_payload_len), 64'd0);
    check("rst_echo_count", 64'(echo_count), 64'd0);
    check("rst_drop_count", 64'(drop_count), 64'd0);
    rst = 1'b0;
    tick();

    // 10-byte payload 01..0A from 10.0.0.2:5555
    tx_ready = 1'b1;
    for (int i = 0; i < 10; i++) pay[i] = 8'(i + 1);
    exp_pay = pay;
    send_dgram(16'd7, 32'h0A000002, 16'd5555, 16'd10, 10, 1'b0, 1'b0);
    exp_echo++;
    wait_commits(1, 40);
    check("t1_latency", 64'(start_cyc - rxc_cyc), 64'd2);
    check("t1_words", 64'(dq.size()), 64'd3);
    if (dq.size() >= 3) begin
      check("t1_w0", 64'(dq[0]), 64'h01020304);
      check("t1_w1", 64'(dq[1]), 64'h05060708);
      check("t1_w2", 64'(dq[2]), 64'h090A0000);
      check("t1_bv2", 64'(bq[2]), 64'd2);
    end
    check_echo(32'h0A000002, 16'd5555, 10);

    // wrong port is ignored silently
    c0 = commits;
    fill_random(16);
    send_dgram(16'd53, 32'h0A000003, 16'd1234, 16'd16, 16, 1'b0, 1'b0);
    check_quiet("port53", c0);

    // rx_drop ends the datagram
    fill_random(8);
    send_dgram(16'd7, 32'h0A000004, 16'd4000, 16'd8, 8, 1'b1, 1'b0);
    exp_drop++;
    check_quiet("rxdrop", c0);

    // short delivery against the claimed length
    fill_random(8);
    send_dgram(16'd7, 32'h0A000005, 16'd4001, 16'd12, 8, 1'b0, 1'b0);
    exp_drop++;
    check_quiet("short", c0);

    // busy: second matching start while holding in TX_WAIT
    tx_ready = 1'b0;
    len = $urandom_range(20, 40);
    fill_random(len);
    exp_pay = pay;
    send_dgram(16'd7, 32'hC0A80109, 16'd6000, 16'(len), len, 1'b0, 1'b1);
    fill_random(8);
    send_dgram(16'd7, 32'hC0A8010A, 16'd6001, 16'd8, 8, 1'b0, 1'b0);
    exp_drop++;
    repeat (50) tick();
    check("busy_no_tx", 64'(hq.size()), 64'd0);
    check("busy_drop_count", 64'(drop_count), 64'(exp_drop));
    tx_ready = 1'b1;
    exp_echo++;
    wait_commits(c0 + 1, 200);
    check_echo(32'hC0A80109, 16'd6000, len);

    // maximum payload
    fill_random(1024);
    exp_pay = pay;
    send_dgram(16'd7, 32'h0A0000FE, 16'd7777, 16'd1024, 1024, 1'b0, 1'b0);
    exp_echo++;
    wait_commits(c0 + 2, 600);
    check("max_latency", 64'(start_cyc - rxc_cyc), 64'd2);
    check_echo(32'h0A0000FE, 16'd7777, 1024);

    // one word past the maximum
    c0 = commits;
    fill_random(1028);
    send_dgram(16'd7, 32'h0A0000FD, 16'd7778, 16'd1028, 0, 1'b0, 1'b0);
    exp_drop++;
    check_quiet("oversize", c0);

    // randomized datagrams against the model
    for (int k = 0; k < 10; k++) begin
      c0 = commits;
      dp = ($urandom_range(0, 3) == 0) ? 16'd53 : 16'd7;
      len = $urandom_range(2, 64);
      mode = $urandom_range(0, 3);
      nb = (mode == 1) ? ((len > 2) ? len - 1 : len + 1) : len;
      fill_random(nb);
      exp_pay = pay;
      tx_ready = ($urandom_range(0, 1) == 1);
      send_dgram(dp, 32'hAC100000 + 32'(k), 16'(1000 + k), 16'(len), nb, (mode == 0), 1'b1);
      repeat ($urandom_range(0, 5)) tick();
      tx_ready = 1'b1;
      if (dp == 16'd7 && mode >= 2) begin
        exp_echo++;
        wait_commits(c0 + 1, 100);
        check_echo(32'hAC100000 + 32'(k), 16'(1000 + k), len);
      end else begin
        if (dp == 16'd7) exp_drop++;
        check_quiet("rand", c0);
      end
    end

    // reset in the middle of TX_DATA
    c0 = commits;
    fill_random(40);
    send_dgram(16'd7, 32'h0A000010, 16'd9000, 16'd40, 40, 1'b0, 1'b0);
    n = 0;
    while (dq.size() < 3 && n < 50) begin
      tick();
      n++;
    end
    check("rst_mid_reached_data", 64'(dq.size() >= 3), 64'd1);
    rst = 1'b1;
    tick();
    check("rstmid_tx_start", 64'(tx_start), 64'd0);
    check("rstmid_tx_data_valid", 64'(tx_data_valid), 64'd0);
    check("rstmid_tx_data", 64'(tx_data), 64'd0);
    check("rstmid_tx_bytes_valid", 64'(tx_bytes_valid), 64'd0);
    check("rstmid_tx_commit", 64'(tx_commit), 64'd0);
    check("rstmid_tx_dst_ip", 64'(tx_dst_ip), 64'd0);
    check("rstmid_tx_dst_port", 64'(tx_dst_port), 64'd0);
    check("rstmid_echo_count", 64'(echo_count), 64'd0);
    check("rstmid_drop_count", 64'(drop_count), 64'd0);
    rst = 1'b0;
    exp_echo = 0;
    exp_drop = 0;
    repeat (10) tick();
    check("rstmid_no_commit", 64'(commits), 64'(c0));
    hq.delete();
    dq.delete();
    bq.delete();
    len = 13;
    fill_random(len);
    exp_pay = pay;
    send_dgram(16'd7, 32'h0A000011, 16'd9001, 16'(len), len, 1'b0, 1'b0);
    exp_echo++;
    wait_commits(c0 + 1, 40);
    check_echo(32'h0A000011, 16'd9001, len);
    check("final_drop_count", 64'(drop_count), 64'(exp_drop));

    check("tx_data_zero_when_idle", 64'(idle_nz), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
